seq_restoring_divider: RTL and testbench

- Iterative restoring integer divider; computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock.
- Companion to the multiplier datapath: performs the inverse operation for the same operand widths.
- Sits behind a valid/ready request channel and a valid/ready result channel.
- Processes one division at a time; no overlap of requests.

---
 rtl/vdiv_pkg.sv | 26 ++
 rtl/vdiv_step.sv | 34 +++
 rtl/seq_restoring_divider.sv | 162 ++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/vdiv_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state encoding, the default operand width and a
// constant-evaluable ceil(log2) used to size the iteration counter.
package vdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } vdiv_state_e;

    localparam int VDIV_WIDTH = 8;

    // ceil(log2(value)); the callers size the counter with clog2(WIDTH+1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vdiv_step.sv
// One restoring-division stage: shift in a dividend bit, compare, subtract.
// Latency: purely combinational, no state.
// Backpressure: none; the enclosing divider decides when the result is taken.
//
// Ports:
//   rem_in   - partial remainder before this step (always < divisor)
//   bit_in   - next dividend bit, MSB first
//   divisor  - divisor magnitude
//   rem_out  - partial remainder after this step
//   q_bit    - quotient bit produced by this step
module vdiv_step
    import vdiv_pkg::*;
#(
    parameter int WIDTH = VDIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // WIDTH+1 bits: the shifted remainder can reach 2*divisor-1.
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    assign trial = {rem_in, bit_in};
    assign diff  = trial - {1'b0, divisor};
    assign q_bit = (trial >= {1'b0, divisor});

    // When the subtraction is skipped, trial < divisor, so it fits in WIDTH bits.
    assign rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider, one quotient bit per clock (optional signed mode: VDIV_SIGNED_EN).
// Latency: WIDTH edges after the accepting edge; divide-by-zero is ready right after the accepting edge.
// Backpressure: result held in DONE until out_ready; start_ready only in IDLE.
//
// Ports:
//   clk, rst_n                     - clock, async active-low reset
//   start_valid/start_ready        - request channel, dividend/divisor sampled on handshake
//   out_valid/out_ready            - result channel
//   quotient, remainder            - result, held stable from DONE through IDLE
//   div_by_zero                    - result came from a zero divisor
module seq_restoring_divider
    import vdiv_pkg::*;
#(
    parameter int WIDTH = VDIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = clog2(WIDTH + 1);

    vdiv_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    // work_q starts as the dividend; each step shifts its MSB out into the
    // stage and shifts the new quotient bit in at the LSB.
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dsr_q;

    logic [WIDTH-1:0] rem_nxt;
    logic             q_bit;
    logic             accept;
    logic             last_step;
    logic             dsr_zero;
    logic [WIDTH-1:0] load_dvd;
    logic [WIDTH-1:0] load_dsr;
    logic [WIDTH-1:0] raw_q;
    logic [WIDTH-1:0] raw_r;
    logic [WIDTH-1:0] fin_q;
    logic [WIDTH-1:0] fin_r;

    assign start_ready = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign accept      = start_valid && start_ready;
    assign last_step   = (state_q == CALC) && (cnt_q == CNT_W'(WIDTH - 1));
    assign dsr_zero    = (divisor == '0);

    vdiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (work_q[WIDTH-1]),
        .divisor (dsr_q),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    assign raw_q = {work_q[WIDTH-2:0], q_bit};
    assign raw_r = rem_nxt;

`ifdef VDIV_SIGNED_EN
    // The core divides magnitudes; signs are re-applied on the final step.
    logic q_neg_q;
    logic r_neg_q;

    assign load_dvd = dividend[WIDTH-1] ? -dividend : dividend;
    assign load_dsr = divisor[WIDTH-1]  ? -divisor  : divisor;
    // Most-negative / -1 gives magnitude 2^(WIDTH-1) with a positive sign,
    // which wraps back to most-negative: the defined overflow result.
    assign fin_q    = q_neg_q ? -raw_q : raw_q;
    assign fin_r    = r_neg_q ? -raw_r : raw_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (accept) begin
            q_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_q <= dividend[WIDTH-1];
        end
    end
`else
    assign load_dvd = dividend;
    assign load_dsr = divisor;
    assign fin_q    = raw_q;
    assign fin_r    = raw_r;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = dsr_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A request presented alongside out_ready waits for IDLE.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            work_q      <= '0;
            rem_q       <= '0;
            dsr_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt_q  <= '0;
            work_q <= load_dvd;
            rem_q  <= '0;
            dsr_q  <= load_dsr;
            if (dsr_zero) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                div_by_zero <= 1'b0;
            end
        end else if (state_q == CALC) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            work_q <= raw_q;
            rem_q  <= rem_nxt;
            // Outputs only change once the full result is known.
            if (last_step) begin
                quotient  <= fin_q;
                remainder <= fin_r;
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider at WIDTH=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_seq_restoring_divider;

    logic       clk;
    logic       rst_n;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_cmp;
    int n_bad;

    seq_restoring_divider #(
        .WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, take it on the next edge, then scramble the
    // operand inputs so any late sampling shows up in the result.
    task automatic send_req(input logic [7:0] dvd, input logic [7:0] dsr);
        start_valid = 1'b1;
        dividend    = dvd;
        divisor     = dsr;
        tick();
        start_valid = 1'b0;
        dividend    = 8'($urandom);
        divisor     = 8'($urandom);
    endtask

    // Count edges after the accepting edge until out_valid, watching that
    // start_ready stays low and the result outputs stay frozen meanwhile.
    task automatic wait_result(input string tag, input int exp_lat);
        int         lat;
        int         rdy_bad;
        int         vis_bad;
        logic [7:0] q_hold;
        logic [7:0] r_hold;
        lat     = 0;
        rdy_bad = 0;
        vis_bad = 0;
        q_hold  = quotient;
        r_hold  = remainder;
        while (!out_valid && lat < 40) begin
            if (start_ready) rdy_bad++;
            if (quotient !== q_hold || remainder !== r_hold) vis_bad++;
            tick();
            lat++;
        end
        check({tag, "_latency"}, 8'(lat), 8'(exp_lat));
        check({tag, "_rdy_calc"}, 8'(rdy_bad), 8'd0);
        check({tag, "_hidden_calc"}, 8'(vis_bad), 8'd0);
    endtask

    task automatic pop_result(input string tag);
        check({tag, "_rdy_done"}, 8'(start_ready), 8'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vld_after_pop"}, 8'(out_valid), 8'd0);
        check({tag, "_rdy_after_pop"}, 8'(start_ready), 8'd1);
    endtask

    task automatic run_div(input string tag, input logic [7:0] dvd, input logic [7:0] dsr,
                           input logic [7:0] exp_q, input logic [7:0] exp_r,
                           input logic exp_dbz, input int exp_lat);
        send_req(dvd, dsr);
        wait_result(tag, exp_lat);
        check({tag, "_q"}, quotient, exp_q);
        check({tag, "_r"}, remainder, exp_r);
        check({tag, "_dbz"}, 8'(div_by_zero), 8'(exp_dbz));
        pop_result(tag);
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        dividend    = 8'd0;
        divisor     = 8'd0;
        out_ready   = 1'b0;

        #12;
        check("rst_vld", 8'(out_valid), 8'd0);
        check("rst_rdy", 8'(start_ready), 8'd1);
        check("rst_q", quotient, 8'd0);
        check("rst_r", remainder, 8'd0);
        check("rst_dbz", 8'(div_by_zero), 8'd0);
        #3 rst_n = 1'b1;
        tick();

        // 100 = 14*7 + 2; result appears 8 edges after the accepting edge.
        run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
        // Zero divisor skips CALC: result is present right after the accepting edge.
        run_div("d5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 0);
        check("idle_hold_dbz", 8'(div_by_zero), 8'd1);
        run_div("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 8);
        run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
        run_div("d3_200", 8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 8);

        // Stall in DONE with a competing request on the inputs: 200 = 15*13 + 5.
        send_req(8'd200, 8'd13);
        wait_result("stall", 8);
        start_valid = 1'b1;
        dividend    = 8'd50;
        divisor     = 8'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_vld", 8'(out_valid), 8'd1);
            check("stall_rdy", 8'(start_ready), 8'd0);
            check("stall_q", quotient, 8'd15);
            check("stall_r", remainder, 8'd5);
        end
        // out_ready and start_valid together: only the result is consumed.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop_vld", 8'(out_valid), 8'd0);
        check("pop_rdy", 8'(start_ready), 8'd1);
        start_valid = 1'b0;
        tick();
        check("idle_stays", 8'(start_ready), 8'd1);
        check("idle_hold_q", quotient, 8'd15);
        check("idle_hold_r", remainder, 8'd5);

        // Reset while the fourth CALC step is pending.
        send_req(8'd100, 8'd7);
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 8'(out_valid), 8'd0);
        check("mid_rst_rdy", 8'(start_ready), 8'd1);
        check("mid_rst_q", quotient, 8'd0);
        check("mid_rst_r", remainder, 8'd0);
        #2 rst_n = 1'b1;
        tick();
        run_div("after_rst", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);

`ifdef VDIV_SIGNED_EN
        // -7/2 = -3 r -1; -128/-1 wraps to -128 r 0; 7/-2 = -3 r 1.
        run_div("s_m7_2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 8);
        run_div("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 8);
        run_div("s_7_m2", 8'd7, 8'hFE, 8'hFD, 8'd1, 1'b0, 8);
        run_div("s_m5_0", 8'hFB, 8'd0, 8'hFF, 8'hFB, 1'b1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
